// File: rtl/fifo_pkg.sv
// fifo_pkg: shared pointer width and Gray/binary helpers for both FIFO clock domains
package fifo_pkg;
  localparam int ADDRSIZE = 4;
  typedef logic [ADDRSIZE:0] ptr_t;
  function automatic ptr_t bin2gray(ptr_t b);
    return (b >> 1) ^ b;
  endfunction
  function automatic ptr_t gray2bin(ptr_t g);
    ptr_t b;
    for (int i = 0; i <= ADDRSIZE; i++) b[i] = ^(g >> i);
    return b;
  endfunction
endpackage

// File: rtl/wptr_full_ctrl.sv
// wptr_full_ctrl: write-domain pointer, full/almost-full flags, occupancy and sticky overflow
module wptr_full_ctrl #(
  parameter int ADDRSIZE = fifo_pkg::ADDRSIZE,
  parameter int AFULL_LEVEL = 2**ADDRSIZE - 4
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic                wclr_ovf,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wcount,
  output logic                woverflow
);
  localparam int W = ADDRSIZE + 1;
  logic [ADDRSIZE:0] wbin, wbin_next, wgray_next, rbin, occ_next;
  always_comb begin
    wbin_next = wbin + W'(winc & ~wfull);
    wgray_next = (wbin_next >> 1) ^ wbin_next;
    for (int i = 0; i <= ADDRSIZE; i++) rbin[i] = ^(wq2_rptr >> i);
    occ_next = wbin_next - rbin;
  end
  // flags use the stale synchronized read pointer, so they can only overstate occupancy
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin <= '0;
      wptr <= '0;
      wfull <= 1'b0;
      wcount <= '0;
      walmost_full <= 1'b0;
      woverflow <= 1'b0;
    end else begin
      wbin <= wbin_next;
      wptr <= wgray_next;
      wfull <= wgray_next == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
      wcount <= occ_next;
      walmost_full <= occ_next >= W'(AFULL_LEVEL);
      woverflow <= (winc & wfull) | (woverflow & ~wclr_ovf);
    end
  end
  assign waddr = wbin[ADDRSIZE-1:0];
endmodule

// File: tb/tb_wptr_full_ctrl.sv
// tb_wptr_full_ctrl: scoreboard bench for the write-side pointer/flag controller
module tb_wptr_full_ctrl;
  typedef struct packed {
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic [4:0] wcount;
    logic       wfull;
    logic       waf;
    logic       wovf;
  } exp_t;
  logic       wclk = 0, wrst = 1, winc = 0, wclr_ovf = 0;
  logic [4:0] wq2_rptr = 0;
  logic [3:0] waddr;
  logic [4:0] wptr, wcount;
  logic       wfull, walmost_full, woverflow;
  exp_t       sb[$];
  logic [4:0] m_bin = 0;
  logic       m_full = 0, m_ovf = 0;
  int         errors = 0, checks = 0;

  wptr_full_ctrl #(.ADDRSIZE(4), .AFULL_LEVEL(12)) dut (
    .wclk(wclk), .wrst(wrst), .winc(winc), .wq2_rptr(wq2_rptr), .wclr_ovf(wclr_ovf),
    .waddr(waddr), .wptr(wptr), .wfull(wfull), .walmost_full(walmost_full),
    .wcount(wcount), .woverflow(woverflow)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] g2b(input logic [4:0] g);
    logic [4:0] b;
    b[4] = g[4];
    for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [4:0] b2g(input logic [4:0] b);
    return b ^ {1'b0, b[4:1]};
  endfunction

  task automatic cycle(input logic inc, input logic clr);
    exp_t e;
    logic [4:0] nb, occ;
    winc = inc;
    wclr_ovf = clr;
    nb = m_bin + {4'd0, inc & ~m_full};
    occ = nb - g2b(wq2_rptr);
    e.waddr = nb[3:0];
    e.wptr = b2g(nb);
    e.wcount = occ;
    e.wfull = occ == 5'd16;
    e.waf = occ >= 5'd12;
    e.wovf = (inc & m_full) | (m_ovf & ~clr);
    sb.push_back(e);
    @(posedge wclk);
    #1;
    e = sb.pop_front();
    chk("waddr", {28'd0, waddr}, {28'd0, e.waddr});
    chk("wptr", {27'd0, wptr}, {27'd0, e.wptr});
    chk("wcount", {27'd0, wcount}, {27'd0, e.wcount});
    chk("wfull", {31'd0, wfull}, {31'd0, e.wfull});
    chk("walmost_full", {31'd0, walmost_full}, {31'd0, e.waf});
    chk("woverflow", {31'd0, woverflow}, {31'd0, e.wovf});
    m_bin = nb;
    m_full = e.wfull;
    m_ovf = e.wovf;
    winc = 0;
    wclr_ovf = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_waddr"}, {28'd0, waddr}, 0);
    chk({tag, "_wptr"}, {27'd0, wptr}, 0);
    chk({tag, "_wcount"}, {27'd0, wcount}, 0);
    chk({tag, "_flags"}, {29'd0, wfull, walmost_full, woverflow}, 0);
  endtask

  initial begin
    logic [4:0] prev;
    #1 chk_zero("rst_init");
    @(posedge wclk);
    #1 wrst = 0;
    repeat (3) cycle(1, 0);
    #2 winc = 1;
    wrst = 1;
    #1 chk_zero("rst_async");
    @(posedge wclk);
    #1 chk_zero("rst_hold");
    wrst = 0;
    m_bin = 0;
    m_full = 0;
    m_ovf = 0;
    cycle(0, 0);
    for (int i = 1; i <= 16; i++) begin
      cycle(1, 0);
      if (i == 11) chk("afull_pre12", {31'd0, walmost_full}, 0);
      if (i == 12) chk("afull_at12", {31'd0, walmost_full}, 1);
    end
    chk("fill_wptr", {27'd0, wptr}, 32'b11000);
    chk("fill_wfull", {31'd0, wfull}, 1);
    repeat (3) cycle(1, 0);
    chk("ovf_wptr", {27'd0, wptr}, 32'b11000);
    chk("ovf_set", {31'd0, woverflow}, 1);
    cycle(1, 1);
    chk("ovf_set_wins", {31'd0, woverflow}, 1);
    cycle(0, 1);
    chk("ovf_clr", {31'd0, woverflow}, 0);
    wq2_rptr = 5'b00110;
    cycle(0, 0);
    chk("rel_wcount", {27'd0, wcount}, 12);
    chk("rel_wfull", {31'd0, wfull}, 0);
    repeat (3) cycle(1, 0);
    chk("simul_pre", {27'd0, wcount}, 15);
    wq2_rptr = b2g(5'd5);
    cycle(1, 0);
    chk("simul_wcount", {27'd0, wcount}, 15);
    chk("simul_wfull", {31'd0, wfull}, 0);
    wq2_rptr = wptr;
    cycle(0, 0);
    for (int i = 0; i < 40; i++) begin
      prev = wptr;
      cycle(1, 0);
      wq2_rptr = prev;
      if (wcount > 5'd2 || wfull) chk("wrap_bound", {26'd0, wfull, wcount}, 2);
    end
    chk("wrap_waddr", {28'd0, waddr}, 32'd12);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wptr_full_ctrl.md
# wptr_full_ctrl

Write-side pointer and full-flag controller for the asynchronous FIFO. It runs entirely in the write clock domain and drives the write address into the dual-port FIFO memory. It qualifies writes against the full flag and publishes a Gray-coded write pointer for synchronization into the read domain. It also reports occupancy, an almost-full warning and a sticky overflow error, all computed against the already-synchronized read pointer.

## Interface
Parameters:
- ADDRSIZE, 4, memory address bits; DEPTH = 2**ADDRSIZE entries
- AFULL_LEVEL, DEPTH-4, occupancy at or above which walmost_full asserts; legal range 1..DEPTH

Ports:
- wclk  input  1  write-domain clock; the block's only clock
- wrst  input  1  reset, asynchronous, active-high
- winc  input  1  write request from the producer
- wq2_rptr  input  ADDRSIZE+1  read pointer, Gray code, already 2-flop synchronized into wclk
- wclr_ovf  input  1  clears woverflow
- waddr  output  ADDRSIZE  binary write address to memory
- wptr  output  ADDRSIZE+1  Gray write pointer to the read-domain synchronizer
- wfull  output  1  FIFO full; memory write enable is winc & ~wfull
- walmost_full  output  1  occupancy >= AFULL_LEVEL
- wcount  output  ADDRSIZE+1  occupancy as seen from the write side, 0..DEPTH
- woverflow  output  1  sticky flag: a write was attempted while full

## Operation
- Internal state: wbin, a binary counter of ADDRSIZE+1 bits (one extra wrap bit).
  - wbin_next = wbin + (winc & ~wfull), modulo 2**(ADDRSIZE+1).
  - wgray_next = (wbin_next >> 1) ^ wbin_next.
- Outputs from the counter:
  - waddr = wbin[ADDRSIZE-1:0].
  - wptr is a register that loads wgray_next every cycle.
- Full detection is registered: wfull <= (wgray_next == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
- Occupancy is registered: wcount <= wbin_next - gray2bin(wq2_rptr), modulo 2**(ADDRSIZE+1).
  - wcount is DEPTH exactly when the full condition holds.
- walmost_full is registered: walmost_full <= (occupancy_next >= AFULL_LEVEL), where occupancy_next is the same value loaded into wcount.
- Overflow:
  - woverflow sets when winc & wfull in a cycle.
  - wclr_ovf clears it.
  - If set and clear happen in the same cycle, set wins.
  - An overflowing write never advances wbin.
- Flags are pessimistic by design. The read pointer is delayed by synchronization, so wfull, walmost_full and wcount may overstate occupancy. They never understate it.
- No separate FSM. State is wbin, wptr, the three flag registers and wcount.

## Timing
- Reset (wrst high, asynchronous): wbin, waddr, wptr, wcount, wfull, walmost_full and woverflow all go to 0 immediately and hold until the first wclk edge after wrst falls.
- Write latency: a write accepted at edge N advances waddr, wptr and wcount at edge N.
  - If that write fills the FIFO, wfull is high from edge N onward.
  - A second write in that cycle is therefore blocked.
- Full release: wfull drops at the first wclk edge after wq2_rptr shows at least one read. Total read-to-release latency is the external synchronizer delay plus one wclk.
- Wrap-around:
  - wbin rolls from 2**(ADDRSIZE+1)-1 to 0 without any flag glitch.
  - waddr wraps every DEPTH writes.
- Simultaneous write and pointer update in one cycle: both are folded into the same next-state computation, so the count is exact for that cycle.
- Reset mid-operation: all state clears asynchronously and any in-flight write is dropped. The read domain must be reset in the same reset window.

## Structure
- Shared package fifo_pkg holds:
  - ADDRSIZE default
  - functions bin2gray and gray2bin, parameterized by width through an ADDRSIZE+1 typedef ptr_t
- Those functions are reused by the read-side controller.
- One sub-module is natural: sync_r2w, a 2-flop Gray pointer synchronizer. It sits outside this block and feeds wq2_rptr. This block itself has no sub-modules.

## Test plan
All scenarios use ADDRSIZE=4 and AFULL_LEVEL=12.
- Reset: assert wrst mid-cycle with winc=1 -> all outputs 0 asynchronously; waddr=0 after release.
- Fill: 16 writes, wq2_rptr=0 -> walmost_full at the 12th edge, wfull at the 16th edge, wptr=5'b11000, wcount=16, waddr=0.
- Overflow: winc=1 while full for 3 cycles -> waddr/wptr unchanged, woverflow=1; pulse wclr_ovf together with winc -> woverflow stays 1; wclr_ovf alone -> woverflow 0.
- Release: while full, set wq2_rptr=5'b00110 (binary 4) -> wfull=0 and wcount=12 at the next edge, walmost_full=1.
- Wrap: 40 writes with wq2_rptr tracking wptr delayed 2 cycles -> wbin passes 31->0, wfull never asserts, wcount <= 2 throughout.
- Simultaneous: at wcount=15, write and wq2_rptr +1 in the same cycle -> wcount stays 15, wfull=0.
